// File: rtl/partition_xfer_packer_pkg.sv
// Shared encodings and defaults for the partition boundary packer.
// Imported by the lane packer and the top-level FSM.
package partition_xfer_packer_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } pxp_state_e;

endpackage

// File: rtl/partition_lane_packer.sv
// Lane counter and indexed write buffer.
// Packs boundary words LSB-first into one wide word.
module partition_lane_packer
  import partition_xfer_packer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W*NWORDS-1:0] pack_q,
  output logic [WORD_W*NWORDS-1:0] pack_wr,
  output logic                     last_lane
);

  localparam int OUT_W  = WORD_W * NWORDS;
  localparam int LANE_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [LANE_W-1:0] LAST = LANE_W'(NWORDS - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0]  pack_d;

  assign last_lane = (lane_q == LAST);

  // pack_wr is the buffer with this cycle's write applied, so a
  // same-cycle last word can be published without waiting a cycle.
  always_comb begin
    pack_wr = pack_q;
    if (wr_en)
      pack_wr[lane_q*WORD_W +: WORD_W] = din;
  end

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_wr;
    if (clr) begin
      lane_d = '0;
      pack_d = '0;
    end else if (wr_en) begin
      lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/partition_xfer_packer.sv
// Collects NWORDS solver words per time step and publishes the packed
// word with a one-cycle valuation strobe at the step boundary.
module partition_xfer_packer
  import partition_xfer_packer_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int NWORDS     = NWORDS_DEF,
  parameter int STEP_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_start,
  input  logic                     step_end,
  input  logic [WORD_W-1:0]        din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [WORD_W*NWORDS-1:0] pdata,
  output logic                     valuation_sig,
  output logic [STEP_CNT_W-1:0]    step_count,
  output logic                     underrun_err,
  output logic                     overrun_err,
  input  logic                     err_clr
);

  localparam int OUT_W = WORD_W * NWORDS;

  pxp_state_e state_q, state_d;

  logic [OUT_W-1:0]      pdata_q, pdata_d;
  logic                  vsig_q, vsig_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  und_q, und_d;
  logic                  ovr_q, ovr_d;

  logic             clr, xfer, last_lane, complete;
  logic             pub, und_set, ovr_set;
  logic [OUT_W-1:0] pack_q, pack_wr;

  assign din_ready = (state_q == COLLECT);
  assign xfer      = din_valid & din_ready;
  assign complete  = xfer & last_lane;

  partition_lane_packer #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS)
  ) u_lane (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (xfer),
    .din       (din),
    .pack_q    (pack_q),
    .pack_wr   (pack_wr),
    .last_lane (last_lane)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    pub     = 1'b0;
    und_set = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        und_set = step_end;
        if (step_start) begin
          clr     = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (step_end) begin
          pub     = complete;
          und_set = ~complete;
          clr     = 1'b1;
          state_d = step_start ? COLLECT : IDLE;
        end else if (step_start) begin
          ovr_set = 1'b1;
          clr     = 1'b1;
          state_d = COLLECT;
        end else if (complete) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (step_end) begin
          pub     = 1'b1;
          clr     = 1'b1;
          state_d = step_start ? COLLECT : IDLE;
        end else if (step_start) begin
          ovr_set = 1'b1;
          clr     = 1'b1;
          state_d = COLLECT;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    vsig_d  = pub;
    pdata_d = pub ? pack_wr : pdata_q;
    cnt_d   = cnt_q + (pub ? STEP_CNT_W'(1) : '0);
    und_d   = und_set | (und_q & ~err_clr);
    ovr_d   = ovr_set | (ovr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pdata_q <= '0;
      vsig_q  <= 1'b0;
      cnt_q   <= '0;
      und_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pdata_q <= pdata_d;
      vsig_q  <= vsig_d;
      cnt_q   <= cnt_d;
      und_q   <= und_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pdata         = pdata_q;
  assign valuation_sig = vsig_q;
  assign step_count    = cnt_q;
  assign underrun_err  = und_q;
  assign overrun_err   = ovr_q;

endmodule

// File: tb/tb_partition_xfer_packer.sv
// Directed vector bench for partition_xfer_packer.
module tb_partition_xfer_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_start = 1'b0;
  logic        step_end = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] pdata;
  logic        valuation_sig;
  logic [1:0]  step_count;
  logic        underrun_err;
  logic        overrun_err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  partition_xfer_packer #(
    .WORD_W     (16),
    .NWORDS     (4),
    .STEP_CNT_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .step_start    (step_start),
    .step_end      (step_end),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .pdata         (pdata),
    .valuation_sig (valuation_sig),
    .step_count    (step_count),
    .underrun_err  (underrun_err),
    .overrun_err   (overrun_err),
    .err_clr       (err_clr)
  );

  typedef struct {
    logic        rs, st, en, dv, clr;
    logic [15:0] din;
    logic        rdy, vs;
    logic [63:0] pd;
    logic [1:0]  cnt;
    logic        und, ovr;
  } vec_t;

  vec_t tv[$];

  localparam logic [63:0] P1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] P2 = 64'h000D_000C_000B_000A;
  localparam logic [63:0] P3 = 64'h0040_0030_0020_0010;
  localparam logic [63:0] P4 = 64'h0080_0070_0060_0050;
  localparam logic [63:0] P5 = 64'h0004_0003_0002_0001;

  task automatic add(input logic rs, st, en, dv, clr,
                     input logic [15:0] d,
                     input logic rdy, vs,
                     input logic [63:0] pd,
                     input logic [1:0] cnt,
                     input logic und, ovr);
    vec_t v;
    v.rs = rs; v.st = st; v.en = en; v.dv = dv; v.clr = clr;
    v.din = d; v.rdy = rdy; v.vs = vs; v.pd = pd;
    v.cnt = cnt; v.und = und; v.ovr = ovr;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, st, en, dv, clr,
                       input logic [15:0] d);
    rst = rs; step_start = st; step_end = en;
    din_valid = dv; err_clr = clr; din = d;
  endtask

  initial begin
    //   rs st en dv cl din      rdy vs pd  cnt und ovr
    add(1, 0, 0, 0, 0, 16'h0,    0, 0, 0,  0, 0, 0);
    // nominal collect
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h1111, 1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h2222, 1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h3333, 1, 0, 0,  0, 0, 0);
    add(0, 0, 0, 1, 0, 16'h4444, 0, 0, 0,  0, 0, 0);
    // backpressure in HOLD, then publish
    add(0, 0, 0, 1, 0, 16'h5555, 0, 0, 0,  0, 0, 0);
    add(0, 0, 1, 1, 0, 16'h5555, 0, 1, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h5555, 0, 0, P1, 1, 0, 0);
    // underrun
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0101, 1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0202, 1, 0, P1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 16'h0,    0, 0, P1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0,    0, 0, P1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 16'h0,    0, 0, P1, 1, 0, 0);
    // overrun from HOLD
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0001, 1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0002, 1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0003, 1, 0, P1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0004, 0, 0, P1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000A, 1, 0, P1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000B, 1, 0, P1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000C, 1, 0, P1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000D, 0, 0, P1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 16'h0,    0, 1, P2, 2, 0, 1);
    add(0, 0, 0, 0, 1, 16'h0,    0, 0, P2, 2, 0, 0);
    // last word with step_end in COLLECT
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P2, 2, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0010, 1, 0, P2, 2, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0020, 1, 0, P2, 2, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0030, 1, 0, P2, 2, 0, 0);
    add(0, 0, 1, 1, 0, 16'h0040, 0, 1, P3, 3, 0, 0);
    // step_end + step_start in HOLD; counter wraps
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0050, 1, 0, P3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0060, 1, 0, P3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0070, 1, 0, P3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 16'h0080, 0, 0, P3, 3, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0,    1, 1, P4, 0, 0, 0);
    // overrun inside COLLECT, then reset mid-step
    add(0, 1, 0, 0, 0, 16'h0,    1, 0, P4, 0, 0, 1);
    add(0, 0, 0, 1, 0, 16'h0009, 1, 0, P4, 0, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000A, 1, 0, P4, 0, 0, 1);
    add(0, 0, 0, 1, 0, 16'h000B, 1, 0, P4, 0, 0, 1);
    add(1, 0, 0, 1, 0, 16'h000C, 0, 0, 0,  0, 0, 0);
    // step_end in IDLE; set beats clear
    add(0, 0, 1, 0, 0, 16'h0,    0, 0, 0,  0, 1, 0);
    add(0, 0, 1, 0, 1, 16'h0,    0, 0, 0,  0, 1, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rs, tv[i].st, tv[i].en, tv[i].dv, tv[i].clr,
            tv[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d din_ready", i), 64'(din_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d valuation", i), 64'(valuation_sig), 64'(tv[i].vs));
      chk($sformatf("v%0d pdata", i), pdata, tv[i].pd);
      chk($sformatf("v%0d step_count", i), 64'(step_count), 64'(tv[i].cnt));
      chk($sformatf("v%0d underrun", i), 64'(underrun_err), 64'(tv[i].und));
      chk($sformatf("v%0d overrun", i), 64'(overrun_err), 64'(tv[i].ovr));
    end

    // handshake-driven step with bounded wait for the strobe
    drive(0, 0, 0, 0, 1, 16'h0);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 16'h0);
    @(posedge clk); #1;
    for (int w = 1; w <= 4; w++) begin
      int guard;
      guard = 0;
      drive(0, 0, 0, 1, 0, 16'(w));
      while (!din_ready && guard < 10) begin
        @(posedge clk); #1;
        guard++;
      end
      chk($sformatf("hs word%0d ready", w), 64'(din_ready), 64'd1);
      @(posedge clk); #1;
    end
    drive(0, 0, 1, 0, 0, 16'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 16'h0);
    begin
      int guard;
      guard = 0;
      while (!valuation_sig && guard < 5) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("hs strobe seen", 64'(valuation_sig), 64'd1);
      chk("hs strobe latency", 64'(guard), 64'd0);
    end
    chk("hs pdata", pdata, P5);
    chk("hs step_count", 64'(step_count), 64'd1);
    chk("hs underrun clr", 64'(underrun_err), 64'd0);
    @(posedge clk); #1;
    chk("hs strobe width", 64'(valuation_sig), 64'd0);
    chk("hs pdata hold", pdata, P5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
